// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK register bank.
package jk_pkg;

  // Operation select for the bank.
  typedef enum logic [1:0] {
    JK_HOLD  = 2'b00,
    JK_JK    = 2'b01,
    JK_LOAD  = 2'b10,
    JK_COUNT = 2'b11
  } jk_mode_t;

  // Single-bit JK next-state: hold, clear, set, toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      2'b11:   r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop bit with synchronous reset, enable and parallel load.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic load,
  input  logic d,
  output logic q
);

  // Bit state: reset wins, then enable gates load or the JK update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (!en) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      q <= jk_next(q, j, k);
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Parametrised bank of JK flip-flops with JK, load, hold and up/down count modes.
// Optional build macro JK_REG_BANK_SAT_EN: COUNT saturates at the bound instead
// of wrapping, and tc becomes a level flag while parked at the bound.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             chg
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] toggle_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic             load_s;
  logic [WIDTH-1:0] next_s;
  logic             at_bound_s;
  logic             count_s;
  logic             tc_next_s;

  assign q = q_s;

  // Bound in the current direction: all-ones going up, zero going down.
  always_comb begin
    if (up) begin
      at_bound_s = &q_s;
    end else begin
      at_bound_s = ~(|q_s);
    end
  end

  // Toggle chain: bit i flips when every lower bit sits at the carry/borrow value.
  always_comb begin
    toggle_s    = {WIDTH{1'b0}};
    toggle_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if (up) begin
        toggle_s[i] = toggle_s[i-1] & q_s[i-1];
      end else begin
        toggle_s[i] = toggle_s[i-1] & ~q_s[i-1];
      end
    end
`ifdef JK_REG_BANK_SAT_EN
    if (at_bound_s) begin
      toggle_s = {WIDTH{1'b0}};
    end else begin
      toggle_s = toggle_s;
    end
`endif
  end

  // Mode decode into per-bit J/K and the load strobe.
  always_comb begin
    j_s    = {WIDTH{1'b0}};
    k_s    = {WIDTH{1'b0}};
    load_s = 1'b0;
    case (jk_mode_t'(mode))
      JK_HOLD: begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
      end
      JK_JK: begin
        j_s = j;
        k_s = k;
      end
      JK_LOAD: begin
        load_s = 1'b1;
      end
      JK_COUNT: begin
        j_s = toggle_s;
        k_s = toggle_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RESET_VAL[gi]),
        .en      (en),
        .j       (j_s[gi]),
        .k       (k_s[gi]),
        .load    (load_s),
        .d       (d[gi]),
        .q       (q_s[gi])
      );
    end
  endgenerate

  // Predicted next q, mirroring the cell update, used for the change flag.
  always_comb begin
    next_s = q_s;
    for (int i = 0; i < WIDTH; i++) begin
      if (!en) begin
        next_s[i] = q_s[i];
      end else if (load_s) begin
        next_s[i] = d[i];
      end else begin
        next_s[i] = jk_next(q_s[i], j_s[i], k_s[i]);
      end
    end
  end

  // Terminal-count condition for the coming edge.
  always_comb begin
    count_s = en & (jk_mode_t'(mode) == JK_COUNT);
`ifdef JK_REG_BANK_SAT_EN
    if (up) begin
      tc_next_s = count_s & (&next_s);
    end else begin
      tc_next_s = count_s & ~(|next_s);
    end
`else
    tc_next_s = count_s & at_bound_s;
`endif
  end

  // Registered status flags; reset edges clear both.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc  <= 1'b0;
      chg <= 1'b0;
    end else begin
      tc  <= tc_next_s;
      chg <= (next_s != q_s);
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank (WIDTH=8, RESET_VAL=8'hA5).
module tb_jk_reg_bank;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             chg;

  int tests_run;
  int tests_failed;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_JK    = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b10;
  localparam logic [1:0] M_COUNT = 2'b11;

  jk_reg_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .j    (j),
    .k    (k),
    .d    (d),
    .up   (up),
    .q    (q),
    .tc   (tc),
    .chg  (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                     input logic [7:0] jv, input logic [7:0] kv,
                     input logic [7:0] dv, input logic u);
    rst  = r;
    en   = e;
    mode = m;
    j    = jv;
    k    = kv;
    d    = dv;
    up   = u;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [7:0] eq, input logic et, input logic ec);
    check({tag, ".q"},   {24'd0, q},   {24'd0, eq});
    check({tag, ".tc"},  {31'd0, tc},  {31'd0, et});
    check({tag, ".chg"}, {31'd0, chg}, {31'd0, ec});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset for two cycles.
    cyc(1'b1, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("reset", 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, M_HOLD, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    chk3("hold_after_reset", 8'hA5, 1'b0, 1'b0);

    // JK truth table across bit pairs.
    cyc(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h0F, 1'b1);
    chk3("load_0f", 8'h0F, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, M_JK, 8'hF0, 8'h3C, 8'h00, 1'b1);
    chk3("jk_f3", 8'hF3, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, M_JK, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("jk_hold", 8'hF3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, M_JK, 8'hFF, 8'hFF, 8'h00, 1'b1);
    chk3("jk_toggle_all", 8'h0C, 1'b0, 1'b1);

    // Load then enable-gated load.
    cyc(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h5A, 1'b1);
    chk3("load_5a", 8'h5A, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, M_LOAD, 8'h00, 8'h00, 8'hFF, 1'b1);
    chk3("en0_load", 8'h5A, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("en0_count", 8'h5A, 1'b0, 1'b0);

    // Up wrap.
    cyc(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'hFE, 1'b1);
    chk3("load_fe", 8'hFE, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
`ifdef JK_REG_BANK_SAT_EN
    chk3("up_ff", 8'hFF, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("up_sat", 8'hFF, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, M_HOLD, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("up_hold", 8'hFF, 1'b0, 1'b0);
`else
    chk3("up_ff", 8'hFF, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("up_wrap", 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, M_HOLD, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("up_hold", 8'h00, 1'b0, 1'b0);
`endif

    // Down wrap.
    cyc(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h01, 1'b0);
    chk3("load_01", 8'h01, 1'b0, 1'b1);
`ifdef JK_REG_BANK_SAT_EN
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
    chk3("dn_00", 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
    chk3("dn_sat", 8'h00, 1'b1, 1'b0);
`else
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
    chk3("dn_00", 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
    chk3("dn_wrap", 8'hFF, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
    chk3("dn_fe", 8'hFE, 1'b0, 1'b1);
`endif

    // Down count across a borrow chain.
    cyc(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h80, 1'b0);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b0);
    chk3("dn_borrow", 8'h7F, 1'b0, 1'b1);

    // Reset in the middle of an up count.
    cyc(1'b0, 1'b1, M_LOAD, 8'h00, 8'h00, 8'h10, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("mid_c1", 8'h11, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("mid_c2", 8'h12, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("mid_rst", 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("mid_c4", 8'hA6, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, M_COUNT, 8'h00, 8'h00, 8'h00, 1'b1);
    chk3("mid_c5", 8'hA7, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised bank of WIDTH JK flip-flops. It generalises the single JK flip-flop into a multi-bit register.
- Per-bit JK operation, parallel load, hold, and an up/down counter mode built from the JK toggle chain.
- Sits behind the same testbench/interface style as the existing JK_FF. It is used as a general status/control register and event counter.

Parameters:
- WIDTH, 8, number of JK bits (1..32)
- RESET_VAL, 0, value of q after reset (WIDTH bits, truncated)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable; 0 forces hold regardless of mode
- mode  input  2  operation select: 00 HOLD, 01 JK, 10 LOAD, 11 COUNT
- j  input  WIDTH  per-bit J (JK mode only)
- k  input  WIDTH  per-bit K (JK mode only)
- d  input  WIDTH  parallel load data (LOAD mode only)
- up  input  1  count direction: 1 up, 0 down (COUNT mode only)
- q  output  WIDTH  register state
- tc  output  1  registered terminal-count flag
- chg  output  1  registered pulse: q changed on the last edge

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst: sampled only at the rising edge of clk.
- Reset values: q=RESET_VAL, tc=0, chg=0. rst has priority over en and mode.
- All updates occur at the rising edge of clk; latency is 1 cycle from inputs to q.
- en=0: q holds; tc=0; chg=0.
- HOLD (00): q holds.
- JK (01), per bit i:
  - j=0,k=0: hold
  - j=0,k=1: clear
  - j=1,k=0: set
  - j=1,k=1: toggle
- LOAD (10): q <= d.
- COUNT (11), implemented as a synchronous JK toggle chain:
  - Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down). Bit 0 always toggles.
  - Arithmetic is modulo 2^WIDTH: up from all-ones wraps to 0; down from 0 wraps to all-ones.
- tc: asserted for exactly one cycle, on the edge where a COUNT-mode step wraps.
  - Up: q goes all-ones -> 0, so tc=1 with q=0 in the same cycle.
  - Down: q goes 0 -> all-ones.
  - tc=0 in every other mode and on every non-wrapping step.
- chg: 1 for the cycle following any edge where the new q differs from the old q (rst edges excluded, chg=0). Otherwise 0.
- Simultaneous events:
  - rst=1 with any mode: reset wins.
  - A mode change takes effect on the same edge. No pipeline and no state machine beyond q/tc/chg.
- Reset mid-count: q returns to RESET_VAL on the next edge; tc and chg clear.
- WIDTH=1: COUNT toggles q each enabled cycle; tc fires on every wrap in the selected direction.

Optional Feature:
- Macro JK_REG_BANK_SAT_EN.
- Defined:
  - COUNT mode saturates: up holds at all-ones, down holds at 0.
  - tc is level-high while q is at the saturation bound in the current direction and mode=COUNT, en=1.
  - chg=0 while saturated.
- Undefined: wrap-around behaviour exactly as specified above.

Decomposition:
- Package jk_pkg:
  - Typedef enum logic [1:0] jk_mode_t {JK_HOLD, JK_JK, JK_LOAD, JK_COUNT}.
  - Function jk_next(q, j, k) giving the single-bit JK next-state.
- Sub-module jk_cell: one bit with inputs clk, rst, rst_val, en, j, k, load, d; output q.
  - Instantiated WIDTH times via generate.
  - In COUNT mode the bank drives j=k=toggle_i. In LOAD mode it drives load=1.
- tc and chg logic lives in jk_reg_bank.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 for 2 cycles -> q=8'hA5, tc=0, chg=0. A release followed by HOLD keeps 8'hA5.
- JK truth table: q=8'h0F, mode=JK, j=8'hF0, k=8'h3C -> next q=8'hF3 (bits 4,5 toggle; 2,3 clear; 6,7 set), chg=1.
- LOAD then HOLD: d=8'h5A, LOAD one cycle -> q=8'h5A. en=0 with mode=LOAD, d=8'hFF -> q stays 8'h5A, chg=0.
- Up wrap: LOAD 8'hFE, COUNT up 2 cycles -> q=8'hFF then 8'h00, with tc=1 only on the 8'h00 cycle.
  - With JK_REG_BANK_SAT_EN: q stays 8'hFF and tc stays 1.
- Down wrap: LOAD 8'h01, COUNT down 3 cycles -> 8'h00, 8'hFF (tc=1), 8'hFE (tc=0).
- Reset mid-count: COUNT up from 8'h10 for 5 cycles, assert rst in cycle 3 -> q=RESET_VAL the next cycle, tc=0, chg=0, and counting resumes from RESET_VAL after release.
